sp_tracker: RTL and testbench

- Parametrised two-axis solar-panel tracker; next generation of the sweep/compare/step-back optimizer.
- Replaces button-driven FSM, step counters and max-voltage register with one block that outputs absolute servo position commands.
- Runs a horizontal sweep, then a vertical sweep, returns to the best pose, then optionally holds it with hysteretic perturb-and-observe.
- Sits between the ADC sample stream (V_IN/V_VALID) and the position-input servo drivers.

---
 rtl/sp_tracker.sv | 219 +++++++++++++++++++++
 tb/tb_sp_tracker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_tracker.sv
// Two-axis solar tracker: H sweep, V sweep, return to the best pose, then an
// optional hysteretic perturb-and-observe hold. Emits absolute servo positions.
module sp_tracker #(
  parameter int VW          = 12,
  parameter int PW          = 8,
  parameter int H_MIN       = 0,
  parameter int H_MAX       = 180,
  parameter int V_MIN       = 0,
  parameter int V_MAX       = 90,
  parameter int STEP        = 2,
  parameter int SETTLE      = 1000,
  parameter int HYST        = 4,
  parameter int DECAY_SHIFT = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic          MODE,
  input  logic [VW-1:0] V_IN,
  input  logic          V_VALID,
  output logic [PW-1:0] POS_H,
  output logic [PW-1:0] POS_V,
  output logic [VW-1:0] MAX_V,
  output logic          BUSY,
  output logic          DONE,
  output logic [2:0]    STATE
);

  localparam int CW  = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int PW1 = PW + 1;
  localparam int VW1 = VW + 1;
  localparam logic [PW-1:0] H_LO = PW'(H_MIN);
  localparam logic [PW-1:0] H_HI = PW'(H_MAX);
  localparam logic [PW-1:0] V_LO = PW'(V_MIN);
  localparam logic [PW-1:0] V_HI = PW'(V_MAX);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_H_SCAN = 3'd1, S_H_RETURN = 3'd2,
    S_V_SCAN = 3'd3, S_V_RETURN = 3'd4, S_TRACK = 3'd5
  } state_t;

  typedef enum logic [1:0] {T_PERTURB, T_WAIT, T_REVERT} phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pos_h, pos_h_n, pos_v, pos_v_n;
  logic [PW-1:0] best_h, best_h_n, best_v, best_v_n;
  logic [PW-1:0] old_pos, old_pos_n;
  logic [VW-1:0] max_v, max_v_n;
  logic          dir, dir_n, axis, axis_n;
  logic          done_q, done_n, busy_q;

  logic [PW-1:0] cur, lo, hi, tgt;
  logic [VW-1:0] decayed;
  logic          sample_ok, win, accept;

  // Positions are widened by one bit so the clamp sees the true sum/difference.
  function automatic logic [PW-1:0] step_up(input logic [PW-1:0] p, input logic [PW-1:0] lim);
    logic [PW:0] s;
    s = {1'b0, p} + PW1'(STEP);
    return (s > {1'b0, lim}) ? lim : s[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] step_dn(input logic [PW-1:0] p, input logic [PW-1:0] lim);
    if ({1'b0, p} < ({1'b0, lim} + PW1'(STEP))) return lim;
    return p - PW'(STEP);
  endfunction

  assign cur       = axis ? pos_v : pos_h;
  assign lo        = axis ? V_LO : H_LO;
  assign hi        = axis ? V_HI : H_HI;
  assign tgt       = dir ? step_dn(cur, lo) : step_up(cur, hi);
  assign sample_ok = (cnt == '0) && V_VALID;
  assign win       = V_IN > max_v;
  assign accept    = {1'b0, V_IN} > ({1'b0, max_v} + VW1'(HYST));
  assign decayed   = max_v - (max_v >> DECAY_SHIFT);

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    cnt_n     = (cnt != '0) ? cnt - CNT_ONE : cnt;
    pos_h_n   = pos_h;
    pos_v_n   = pos_v;
    best_h_n  = best_h;
    best_v_n  = best_v;
    old_pos_n = old_pos;
    max_v_n   = max_v;
    dir_n     = dir;
    axis_n    = axis;

    if ((state == S_IDLE || state == S_TRACK) && START) begin
      state_n  = S_H_SCAN;
      phase_n  = T_PERTURB;
      cnt_n    = CNT_LOAD;
      pos_h_n  = H_LO;
      pos_v_n  = V_LO;
      best_h_n = H_LO;
      best_v_n = V_LO;
      max_v_n  = '0;
    end else begin
      case (state)
        S_H_SCAN: if (sample_ok) begin
          cnt_n = CNT_LOAD;
          if (win) begin
            max_v_n  = V_IN;
            best_h_n = pos_h;
          end
          if (pos_h == H_HI) begin
            state_n = S_H_RETURN;
            pos_h_n = win ? pos_h : best_h;
          end else begin
            pos_h_n = step_up(pos_h, H_HI);
          end
        end
        S_H_RETURN: if (cnt <= CNT_ONE) begin
          state_n = S_V_SCAN;
          pos_v_n = V_LO;
          cnt_n   = CNT_LOAD;
        end
        S_V_SCAN: if (sample_ok) begin
          cnt_n = CNT_LOAD;
          if (win) begin
            max_v_n  = V_IN;
            best_v_n = pos_v;
          end
          if (pos_v == V_HI) begin
            state_n = S_V_RETURN;
            pos_v_n = win ? pos_v : best_v;
          end else begin
            pos_v_n = step_up(pos_v, V_HI);
          end
        end
        S_V_RETURN: if (cnt <= CNT_ONE) begin
          state_n = MODE ? S_TRACK : S_IDLE;
          phase_n = T_PERTURB;
        end
        S_TRACK: begin
          case (phase)
            T_PERTURB: begin
              // A perturbation pinned at a limit fails on the spot, no settle.
              if (tgt == cur) begin
                dir_n   = ~dir;
                axis_n  = ~axis;
                max_v_n = decayed;
              end else begin
                old_pos_n = cur;
                if (axis) pos_v_n = tgt;
                else      pos_h_n = tgt;
                cnt_n   = CNT_LOAD;
                phase_n = T_WAIT;
              end
            end
            T_WAIT: if (sample_ok) begin
              if (accept) begin
                max_v_n = V_IN;
                phase_n = T_PERTURB;
              end else begin
                if (axis) pos_v_n = old_pos;
                else      pos_h_n = old_pos;
                dir_n   = ~dir;
                axis_n  = ~axis;
                max_v_n = decayed;
                cnt_n   = CNT_LOAD;
                phase_n = T_REVERT;
              end
            end
            default: if (cnt <= CNT_ONE) phase_n = T_PERTURB;
          endcase
        end
        default: state_n = S_IDLE;
      endcase
    end

    done_n = (state_n == S_V_RETURN) && (cnt_n == CNT_ONE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      phase   <= T_PERTURB;
      cnt     <= '0;
      pos_h   <= H_LO;
      pos_v   <= V_LO;
      best_h  <= H_LO;
      best_v  <= V_LO;
      old_pos <= H_LO;
      max_v   <= '0;
      dir     <= 1'b0;
      axis    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      cnt     <= cnt_n;
      pos_h   <= pos_h_n;
      pos_v   <= pos_v_n;
      best_h  <= best_h_n;
      best_v  <= best_v_n;
      old_pos <= old_pos_n;
      max_v   <= max_v_n;
      dir     <= dir_n;
      axis    <= axis_n;
      done_q  <= done_n;
      busy_q  <= (state_n != S_IDLE);
    end
  end

  assign POS_H = pos_h;
  assign POS_V = pos_v;
  assign MAX_V = max_v;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign STATE = state;

endmodule

// File: tb/tb_sp_tracker.sv
// Scoreboard bench for sp_tracker: every change of (POS_H, POS_V, MAX_V) is popped
// against a queue of hand-computed expected tuples; a second instance covers the H clamp.
module tb_sp_tracker;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst, rst2, start, start2, mode, v_valid;
  logic [11:0] v_in0, v_in1;
  logic [7:0]  pos_h0, pos_v0, pos_h1, pos_v1;
  logic [11:0] max_v0, max_v1;
  logic        busy0, busy1, done0, done1;
  logic [2:0]  state0, state1;

  always #5 clk = ~clk;

  sp_tracker #(.VW(12), .PW(8), .H_MIN(0), .H_MAX(10), .V_MIN(0), .V_MAX(6), .STEP(2),
               .SETTLE(SETTLE), .HYST(4), .DECAY_SHIFT(4)) dut0 (
    .CLK(clk), .RESET(rst), .START(start), .MODE(mode), .V_IN(v_in0), .V_VALID(v_valid),
    .POS_H(pos_h0), .POS_V(pos_v0), .MAX_V(max_v0), .BUSY(busy0), .DONE(done0), .STATE(state0));

  sp_tracker #(.VW(12), .PW(8), .H_MIN(0), .H_MAX(9), .V_MIN(0), .V_MAX(6), .STEP(2),
               .SETTLE(SETTLE), .HYST(4), .DECAY_SHIFT(4)) dut1 (
    .CLK(clk), .RESET(rst2), .START(start2), .MODE(1'b0), .V_IN(v_in1), .V_VALID(v_valid),
    .POS_H(pos_h1), .POS_V(pos_v1), .MAX_V(max_v1), .BUSY(busy1), .DONE(done1), .STATE(state1));

  typedef struct {int h; int v; int m; int gap;} ev_t;
  ev_t q0[$];
  ev_t q1[$];
  ev_t e0, e1;
  int checks = 0, errors = 0;
  int scen = 0;
  int cyc0 = 0, cyc1 = 0, last_cyc0 = 0, last_cyc1 = 0;
  int done_cnt0 = 0, done_cnt1 = 0;
  logic [27:0] last0 = '0, last1 = '0;

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int model_v(int s, int h, int v);
    case (s)
      0: return 100 - 10 * iabs(h - 6);
      1: return 50;
      2: return 150 - 10 * iabs(h - 6) - 5 * iabs(v - 2);
      default: begin
        if (h == 8 && v == 2)  return 160;
        if (h == 10 && v == 2) return 164;
        if (h == 8 && v == 0)  return 200;
        if (h == 10 && v == 0) return 250;
        return 0;
      end
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push0(input int h, input int v, input int m, input int g);
    ev_t e;
    e.h = h; e.v = v; e.m = m; e.gap = g;
    q0.push_back(e);
  endtask

  task automatic push1(input int h, input int v, input int m, input int g);
    ev_t e;
    e.h = h; e.v = v; e.m = m; e.gap = g;
    q1.push_back(e);
  endtask

  // which: 0 done_cnt0>=t, 1 done_cnt1>=t, 2 pos_h0==t, 3 pos_v0==t, 4 q0 drained
  task automatic wait_for(input int which, input int t, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      case (which)
        0: ok = (done_cnt0 >= t);
        1: ok = (done_cnt1 >= t);
        2: ok = (int'(pos_h0) == t);
        3: ok = (int'(pos_v0) == t);
        default: ok = (q0.size() == 0);
      endcase
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: condition not reached, required value %0d", name, t);
    end
  endtask

  task automatic pulse(input bit second);
    if (second) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
  endtask

  // ADC model: a bogus full-scale value while the bench believes the servo is settling.
  initial begin
    int vv, left0, left1;
    logic [15:0] prev0, prev1;
    vv = 0; left0 = 0; left1 = 0; prev0 = '0; prev1 = '0;
    v_valid = 1'b0; v_in0 = '0; v_in1 = '0;
    forever begin
      @(negedge clk);
      vv = (vv + 1) % 3;
      v_valid = (vv == 0);
      if ({pos_h0, pos_v0} != prev0) left0 = SETTLE;
      if ({pos_h1, pos_v1} != prev1) left1 = SETTLE;
      prev0 = {pos_h0, pos_v0};
      prev1 = {pos_h1, pos_v1};
      if (left0 > 0) begin v_in0 = 12'hFFF; left0--; end
      else v_in0 = 12'(model_v(scen, int'(pos_h0), int'(pos_v0)));
      if (left1 > 0) begin v_in1 = 12'hFFF; left1--; end
      else v_in1 = 12'(10 * int'(pos_h1));
    end
  end

  always @(negedge clk) begin
    cyc0++;
    if ({pos_h0, pos_v0, max_v0} != last0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL event0: unexpected h=%0d v=%0d max=%0d", pos_h0, pos_v0, max_v0);
      end else begin
        e0 = q0.pop_front();
        if (int'(pos_h0) != e0.h || int'(pos_v0) != e0.v || int'(max_v0) != e0.m ||
            (e0.gap != 0 && cyc0 - last_cyc0 != e0.gap)) begin
          errors++;
          $display("FAIL event0: got h=%0d v=%0d max=%0d gap=%0d, expected h=%0d v=%0d max=%0d gap=%0d",
                   pos_h0, pos_v0, max_v0, cyc0 - last_cyc0, e0.h, e0.v, e0.m, e0.gap);
        end
      end
      last0 = {pos_h0, pos_v0, max_v0};
      last_cyc0 = cyc0;
    end
    if (done0) begin
      done_cnt0++;
      check("done_state0", int'(state0), 4);
      check("done_delay0", cyc0 - last_cyc0, SETTLE - 1);
    end
  end

  always @(negedge clk) begin
    cyc1++;
    if ({pos_h1, pos_v1, max_v1} != last1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL event1: unexpected h=%0d v=%0d max=%0d", pos_h1, pos_v1, max_v1);
      end else begin
        e1 = q1.pop_front();
        if (int'(pos_h1) != e1.h || int'(pos_v1) != e1.v || int'(max_v1) != e1.m) begin
          errors++;
          $display("FAIL event1: got h=%0d v=%0d max=%0d, expected h=%0d v=%0d max=%0d",
                   pos_h1, pos_v1, max_v1, e1.h, e1.v, e1.m);
        end
      end
      last1 = {pos_h1, pos_v1, max_v1};
      last_cyc1 = cyc1;
    end
    if (done1) begin
      done_cnt1++;
      check("done_delay1", cyc1 - last_cyc1, SETTLE - 1);
    end
  end

  initial begin
    int m, nm;
    rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pos_h", int'(pos_h0), 0);
    check("rst_pos_v", int'(pos_v0), 0);
    check("rst_max_v", int'(max_v0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_state", int'(state0), 0);
    rst = 1'b0; rst2 = 1'b0;
    repeat (2) @(negedge clk);

    // Clamp: H_MAX=9 must be visited and sampled (f = 10*h, so 9 wins)
    push1(2, 0, 0, 0);  push1(4, 0, 20, 0); push1(6, 0, 40, 0); push1(8, 0, 60, 0);
    push1(9, 0, 80, 0); push1(9, 0, 90, 0); push1(9, 2, 90, 0); push1(9, 4, 90, 0);
    push1(9, 6, 90, 0); push1(9, 0, 90, 0);
    pulse(1'b1);
    wait_for(1, 1, "clamp_done");
    repeat (6) @(negedge clk);
    check("clamp_done_cnt", done_cnt1, 1);
    check("clamp_state", int'(state1), 0);
    check("clamp_busy", int'(busy1), 0);

    // H peak at 6, MODE=0; a START mid H_SCAN must be ignored
    scen = 0;
    push0(2, 0, 40, 0);  push0(4, 0, 60, 0);  push0(6, 0, 80, 0);  push0(8, 0, 100, 0);
    push0(10, 0, 100, 0); push0(6, 0, 100, 0); push0(6, 2, 100, 0); push0(6, 4, 100, 0);
    push0(6, 6, 100, 0); push0(6, 0, 100, 0);
    pulse(1'b0);
    wait_for(2, 4, "hscan_pos4");
    check("hscan_state", int'(state0), 1);
    check("hscan_busy", int'(busy0), 1);
    pulse(1'b0);
    wait_for(0, 1, "peak_done");
    repeat (6) @(negedge clk);
    check("peak_done_cnt", done_cnt0, 1);
    check("peak_state", int'(state0), 0);
    check("peak_busy", int'(busy0), 0);
    check("peak_max_v", int'(max_v0), 100);

    // Ties everywhere: earliest positions kept
    scen = 1;
    push0(0, 0, 0, 0);   push0(2, 0, 50, 0);  push0(4, 0, 50, 0);  push0(6, 0, 50, 0);
    push0(8, 0, 50, 0);  push0(10, 0, 50, 0); push0(0, 0, 50, 0);  push0(0, 2, 50, 0);
    push0(0, 4, 50, 0);  push0(0, 6, 50, 0);  push0(0, 0, 50, 0);
    pulse(1'b0);
    wait_for(0, 2, "tie_done");
    repeat (6) @(negedge clk);
    check("tie_done_cnt", done_cnt0, 2);
    check("tie_state", int'(state0), 0);

    // TRACK: scan to (6,2), then move the peak and follow it into the limits
    scen = 2;
    mode = 1'b1;
    push0(0, 0, 0, 0);    push0(2, 0, 80, 0);   push0(4, 0, 100, 0);  push0(6, 0, 120, 0);
    push0(8, 0, 140, 0);  push0(10, 0, 140, 0); push0(6, 0, 140, 0);  push0(6, 2, 140, 0);
    push0(6, 4, 150, 0);  push0(6, 6, 150, 0);  push0(6, 2, 150, 0);
    pulse(1'b0);
    wait_for(0, 3, "track_done");
    scen = 3;
    push0(8, 2, 150, 0);  push0(8, 2, 160, 0);  push0(10, 2, 160, 1); push0(8, 2, 150, 0);
    push0(8, 0, 150, SETTLE + 1); push0(8, 0, 200, 0); push0(8, 0, 188, 1);
    push0(10, 0, 188, 1); push0(10, 0, 250, 0);
    m = 250;
    for (int k = 0; k < 200; k++) begin
      nm = m - (m >> 4);
      if (nm == m) break;
      push0(10, 0, nm, 1);
      m = nm;
    end
    repeat (2) @(negedge clk);
    check("track_state", int'(state0), 5);
    check("track_busy", int'(busy0), 1);
    wait_for(4, 0, "track_drain");
    repeat (10) @(negedge clk);
    check("track_max_final", int'(max_v0), m);

    // START accepted in TRACK, then RESET aborts mid V_SCAN
    scen = 0;
    mode = 1'b0;
    push0(0, 0, 0, 0);   push0(2, 0, 40, 0);  push0(4, 0, 60, 0);  push0(6, 0, 80, 0);
    push0(8, 0, 100, 0); push0(10, 0, 100, 0); push0(6, 0, 100, 0); push0(6, 2, 100, 0);
    push0(0, 0, 0, 0);
    pulse(1'b0);
    wait_for(3, 2, "vscan_pos2");
    check("vscan_state", int'(state0), 3);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("abort_pos_h", int'(pos_h0), 0);
    check("abort_pos_v", int'(pos_v0), 0);
    check("abort_max_v", int'(max_v0), 0);
    check("abort_busy", int'(busy0), 0);
    check("abort_done", int'(done0), 0);
    check("abort_state", int'(state0), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_abort", int'(state0), 0);
    check("no_done_after_abort", done_cnt0, 3);
    check("queue0_left", q0.size(), 0);
    check("queue1_left", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
